// File: rtl/pipe_if.sv
// Instruction fetch: owns the PC, drives the imem request/ready handshake, holds IF/ID.
// A fetched word reaches IF/ID one edge after imem_ready; stall freezes IF/ID and parks a returned word in a hold buffer.
module pipe_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsource,
    input  logic        id_valid,
    input  logic [31:0] id_pc4,
    input  logic [17:0] imm18,
    input  logic [27:0] index28,
    input  logic [31:0] rd1,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        if_valid_q, if_valid_d;

    logic        redir;
    logic [31:0] target;
    logic [31:0] br_off;
    logic [31:0] pc_plus4;

    // Redirect target from decode; a stalled decode never redirects.
    always_comb begin
        br_off   = {{14{imm18[17]}}, imm18};
        pc_plus4 = pc_q + 32'd4;
        redir    = id_valid & (pcsource != 2'b00) & ~stall;
        target   = pc_plus4;
        case (pcsource)
            2'b01:   target = id_pc4 + br_off;
            2'b10:   target = rd1;
            2'b11:   target = {id_pc4[31:28], index28};
            default: target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_addr_d  = kill_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        if_valid_d   = if_valid_q;

        case (state_q)
            ST_REQ: begin
                if (redir) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    // An unfinished request must still be retired at its old address.
                    if (!imem_ready) begin
                        kill_addr_d = pc_q;
                        state_d     = ST_KILL;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (!stall) begin
                        instr_d    = imem_rdata;
                        pc4_d      = pc_plus4;
                        if_valid_d = 1'b1;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = pc_plus4;
                        state_d      = ST_HOLD;
                    end
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (!stall) begin
                    state_d = ST_REQ;
                    if (redir) begin
                        pc_d       = target;
                        if_valid_d = 1'b0;
                    end else begin
                        instr_d    = hold_instr_q;
                        pc4_d      = hold_pc4_q;
                        if_valid_d = 1'b1;
                    end
                end
            end

            ST_KILL: begin
                if (redir) begin
                    pc_d = target;
                end
                if (!stall) begin
                    if_valid_d = 1'b0;
                end
                if (imem_ready) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            kill_addr_q  <= 32'h0;
            hold_instr_q <= 32'h0;
            hold_pc4_q   <= 32'h0;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_addr_q  <= kill_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            if_valid_q   <= if_valid_d;
        end
    end

    // Request side is purely registered: no path from imem_rdata/imem_ready.
    assign imem_req  = (state_q != ST_HOLD);
    assign imem_addr = (state_q == ST_KILL) ? kill_addr_q : pc_q;
    assign instr     = instr_q;
    assign pc4       = pc4_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_pipe_if.sv
// Bench for pipe_if: random-latency memory, redirect scoreboard, directed corner cases.
module tb_pipe_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc4 = 32'h0;
    logic [17:0] imm18 = 18'h0;
    logic [27:0] index28 = 28'h0;
    logic [31:0] rd1 = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        if_valid;

    int vectors     = 0;
    int miscompares = 0;
    int deliveries  = 0;
    int minw = 0;
    int maxw = 0;
    logic [31:0] redir_q[$];

    pipe_if #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pcsource(pcsource), .id_valid(id_valid),
        .id_pc4(id_pc4), .imm18(imm18), .index28(index28), .rd1(rd1),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .pc4(pc4), .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    // Where decode sends the PC, written as plain address arithmetic.
    function automatic logic [31:0] redirect_target(input logic [1:0] ps, input logic [31:0] p4,
                                                    input logic [17:0] im, input logic [27:0] ix,
                                                    input logic [31:0] r);
        int off;
        off = int'(im);
        if (off >= 131072) off = off - 262144;
        if (ps == 2'b01) return p4 + 32'(off);
        if (ps == 2'b10) return r;
        return (p4 & 32'hF000_0000) | {4'h0, ix};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] ps, input logic [31:0] p4,
                         input logic [17:0] im, input logic [27:0] ix,
                         input logic [31:0] r, input logic st);
        id_valid = v; pcsource = ps; id_pc4 = p4; imm18 = im; index28 = ix; rd1 = r; stall = st;
        if (v && ps != 2'b00 && !st) redir_q.push_back(redirect_target(ps, p4, im, ix, r));
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 32'h0, 18'h0, 28'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset(input int mn, input int mx);
        @(posedge clk); #3;
        idle();
        rst = 1'b0; minw = mn; maxw = mx;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget, input string name);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, imem_addr, a);
    endtask

    // Memory: each request waits a random number of cycles, then returns a word derived from its address.
    initial begin
        bit busy = 1'b0;
        int wait_left = 0;
        forever begin
            @(negedge clk);
            if (!rst || !imem_req) begin
                busy = 1'b0;
                imem_ready = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_left = $urandom_range(maxw, minw);
                end
                if (wait_left == 0) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    busy = 1'b0;
                end else begin
                    imem_ready = 1'b0;
                    imem_rdata = $urandom;
                    wait_left--;
                end
            end
        end
    end

    // Monitor: IF/ID must deliver consecutive words from the current fetch stream, restarted by each redirect.
    initial begin
        logic [31:0] exp_pc, p_addr, p_instr, p_pc4;
        logic        p_req, p_val, redir;
        exp_pc = RESET_PC;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                exp_pc = RESET_PC;
                redir_q.delete();
            end else begin
                redir = id_valid && pcsource != 2'b00 && !stall;
                if (p_req && !imem_ready) begin
                    check("addr_stable", imem_addr, p_addr);
                    check("req_held", {31'h0, imem_req}, 32'd1);
                end
                if (stall) begin
                    check("stall_valid", {31'h0, if_valid}, {31'h0, p_val});
                    check("stall_instr", instr, p_instr);
                    check("stall_pc4", pc4, p_pc4);
                end else if (if_valid) begin
                    check("deliver_pc4", pc4, exp_pc + 32'd4);
                    check("deliver_instr", instr, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    deliveries++;
                end
                if (redir) begin
                    check("redir_bubble", {31'h0, if_valid}, 32'd0);
                    check("redir_q_nonempty", {31'h0, redir_q.size() != 0}, 32'd1);
                    if (redir_q.size() != 0) exp_pc = redir_q.pop_front();
                end
            end
            p_req = imem_req; p_addr = imem_addr; p_val = if_valid;
            p_instr = instr; p_pc4 = pc4;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_if_valid", {31'h0, if_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc4", pc4, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'd1);
        check("rst_addr", imem_addr, RESET_PC);
        @(posedge clk); #3 rst = 1'b1;

        // Zero-wait memory: one fetch per cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("zw_addr", imem_addr, 32'(4 * k));
            if (k > 0) begin
                check("zw_valid", {31'h0, if_valid}, 32'd1);
                check("zw_pc4", pc4, 32'(4 * k));
            end
        end

        // Two wait cycles per request.
        do_reset(2, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("w2_addr", imem_addr, 32'h0);
            check("w2_bubble", {31'h0, if_valid}, 32'd0);
        end
        @(negedge clk);
        check("w2_valid", {31'h0, if_valid}, 32'd1);
        check("w2_pc4", pc4, 32'h4);

        // Async reset while a fetch at 0x40 is outstanding.
        drive(1'b1, 2'b10, 32'h0, 18'h0, 28'h0, 32'h40, 1'b0);
        @(negedge clk); idle();
        wait_addr(32'h40, 20, "rst_mid_addr");
        #2 rst = 1'b0; minw = 0; maxw = 0;
        #1;
        check("arst_instr", instr, 32'h0);
        check("arst_pc4", pc4, 32'h0);
        check("arst_valid", {31'h0, if_valid}, 32'd0);
        check("arst_addr", imem_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        check("rel_addr", imem_addr, RESET_PC);

        // Branch, jr, j with zero-wait memory.
        repeat (2) @(negedge clk);
        drive(1'b1, 2'b01, 32'h100, 18'h3FFF0, 28'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("br_addr", imem_addr, 32'hF0);
        check("br_bubble", {31'h0, if_valid}, 32'd0);
        @(negedge clk); idle();
        @(negedge clk); drive(1'b1, 2'b10, 32'h0, 18'h0, 28'h0, 32'h400, 1'b0);
        @(posedge clk); #1;
        check("jr_addr", imem_addr, 32'h400);
        @(negedge clk); idle();
        @(negedge clk); drive(1'b1, 2'b11, 32'h1000_0010, 18'h0, 28'h0000200, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("j_addr", imem_addr, 32'h1000_0200);
        @(negedge clk); idle();

        // PC wrap.
        @(negedge clk); drive(1'b1, 2'b10, 32'h0, 18'h0, 28'h0, 32'hFFFF_FFFC, 1'b0);
        @(posedge clk); #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); idle();
        @(posedge clk); #1;
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_pc4", pc4, 32'h0);

        // Redirect while a 3-wait request is outstanding.
        do_reset(3, 3);
        @(negedge clk);
        @(negedge clk); drive(1'b1, 2'b10, 32'h0, 18'h0, 28'h0, 32'h80, 1'b0);
        @(posedge clk); #1;
        check("kill_addr", imem_addr, 32'h0);
        check("kill_bubble", {31'h0, if_valid}, 32'd0);
        @(negedge clk); idle();
        wait_addr(32'h80, 12, "kill_next_addr");
        begin
            int n = 0;
            while (!if_valid && n < 12) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("kill_first_pc4", pc4, 32'h84);
        check("kill_first_instr", instr, mem_word(32'h80));

        // Stall for 4 cycles as a fetch completes.
        do_reset(0, 0);
        repeat (3) @(negedge clk);
        drive(1'b0, 2'b00, 32'h0, 18'h0, 28'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hold_no_req", {31'h0, imem_req}, 32'd0);
        end
        @(negedge clk); idle();
        @(posedge clk); #1;
        check("hold_release_valid", {31'h0, if_valid}, 32'd1);

        // Random traffic.
        do_reset(0, 3);
        for (int c = 0; c < 3000; c++) begin
            logic        st, v;
            logic [1:0]  ps;
            logic [31:0] r;
            @(negedge clk);
            st = ($urandom_range(4, 0) == 0);
            v  = ($urandom_range(2, 0) == 0);
            ps = 2'($urandom_range(3, 0));
            r  = ($urandom_range(63, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            drive(v, ps, $urandom & 32'hFFFF_FFFC, 18'($urandom) & 18'h3FFFC,
                  28'($urandom) & 28'hFFF_FFFC, r, st);
        end
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
        check("deliveries_min", {31'h0, deliveries > 200}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
